// File: rtl/control_unit.sv
// control_unit: Moore microsequencer for the fetch/execute T-states of the CPU.
// Every strobe is computed for the state being entered and registered with it.
module control_unit (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IncPC,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  op,
    output logic        Run
);
    typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef struct packed {
        logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
        logic MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, HIin, LOin, OutPortin, CONin;
        logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write;
        logic [4:0] op;
        logic Run;
    } ctrl_t;
    state_t state, nxt;
    ctrl_t ctrl_q, c;
    logic [4:0] opc, imap;
    logic is_ld, is_ldi, is_st, is_r, is_i, is_md, is_br, is_jr, is_jal;
    logic is_in, is_out, is_mfhi, is_mflo, is_halt, ea, alu_y, wb5;
    logic t0, t1, t2, t3, t4, t5, t6, t7;
    logic unused;
    assign unused  = ^IR[26:0];
    assign opc     = IR[31:27];
    assign is_ld   = opc == 5'd0;
    assign is_ldi  = opc == 5'd1;
    assign is_st   = opc == 5'd2;
    assign is_r    = opc >= 5'd3 && opc <= 5'd11;
    assign is_i    = opc >= 5'd12 && opc <= 5'd14;
    assign is_md   = opc == 5'd15 || opc == 5'd16;
    assign is_br   = opc == 5'd18;
    assign is_jr   = opc == 5'd19;
    assign is_jal  = opc == 5'd20;
    assign is_in   = opc == 5'd21;
    assign is_out  = opc == 5'd22;
    assign is_mfhi = opc == 5'd23;
    assign is_mflo = opc == 5'd24;
    assign is_halt = opc == 5'd26;
    assign ea      = is_ldi | is_ld | is_st;
    assign alu_y   = is_r | is_i | ea | is_md;
    assign wb5     = is_r | is_i | is_ldi;
    assign imap    = opc == 5'd12 ? 5'd3 : opc == 5'd13 ? 5'd5 : 5'd6;
    always_comb begin
        nxt = RESET;
        case (state)
            RESET: nxt = T0;
            T0:    nxt = T1;
            T1:    nxt = T2;
            T2:    nxt = T3;
            T3:    nxt = is_halt ? HALT : alu_y | is_br | is_jal ? T4 : T0;
            T4:    nxt = is_jal ? T0 : T5;
            T5:    nxt = wb5 ? T0 : T6;
            T6:    nxt = is_ld | is_st ? T7 : T0;
            T7:    nxt = T0;
            HALT:  nxt = HALT;
            default: nxt = RESET;
        endcase
        // A halt request only takes effect on an instruction boundary
        if (nxt == T0 && Stop) nxt = HALT;
    end
    assign t0 = nxt == T0;
    assign t1 = nxt == T1;
    assign t2 = nxt == T2;
    assign t3 = nxt == T3;
    assign t4 = nxt == T4;
    assign t5 = nxt == T5;
    assign t6 = nxt == T6;
    assign t7 = nxt == T7;
    always_comb begin
        c           = '0;
        c.PCout     = t0 | t3 & is_jal | t4 & is_br;
        c.Zhighout  = t6 & is_md;
        c.Zlowout   = t1 | t5 & (alu_y & ~is_md | is_md) | t6 & is_br & CON_FF;
        c.MDRout    = t2 | t7 & is_ld;
        c.HIout     = t3 & is_mfhi;
        c.LOout     = t3 & is_mflo;
        c.InPortout = t3 & is_in;
        c.Cout      = t4 & (is_i | ea) | t5 & is_br;
        c.MARin     = t0 | t5 & (is_ld | is_st);
        c.MDRin     = t1 | t6 & (is_ld | is_st);
        c.IRin      = t2;
        c.Yin       = t3 & alu_y | t4 & is_br;
        c.Zin       = t0 | t4 & alu_y | t5 & is_br;
        c.PCin      = t1 | t3 & is_jr | t4 & is_jal | t6 & is_br & CON_FF;
        c.IncPC     = t0;
        c.HIin      = t6 & is_md;
        c.LOin      = t5 & is_md;
        c.OutPortin = t3 & is_out;
        c.CONin     = t3 & is_br;
        c.Gra       = t3 & (is_md | is_br | is_jr | is_in | is_out | is_mfhi | is_mflo)
                    | t4 & is_jal | t5 & wb5 | t6 & is_st | t7 & is_ld;
        c.Grb       = t3 & (is_r | is_i | ea) | t4 & is_md;
        c.Grc       = t4 & is_r;
        c.Rin       = t3 & (is_jal | is_in | is_mfhi | is_mflo) | t5 & wb5 | t7 & is_ld;
        c.Rout      = t3 & (is_r | is_i | is_md | is_br | is_jr | is_out)
                    | t4 & (is_r | is_md | is_jal) | t6 & is_st;
        c.BAout     = t3 & ea;
        c.Read      = t1 | t6 & is_ld;
        c.Write     = t7 & is_st;
        c.op        = t4 & (is_r | is_md) ? opc : t4 & is_i ? imap
                    : t4 & ea | t5 & is_br ? 5'd3 : 5'd0;
        c.Run       = nxt != RESET && nxt != HALT;
    end
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state  <= RESET;
            ctrl_q <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= c;
        end
    end
    assign {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
            MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, HIin, LOin, OutPortin, CONin,
            Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, op, Run} = ctrl_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-instruction micro-step table model checked against the DUT every cycle.
module tb_control_unit;
    typedef logic [32:0] vec_t;
    localparam vec_t RUN = 33'd1, WRITE = 33'd1 << 6, READ = 33'd1 << 7, BAOUT = 33'd1 << 8;
    localparam vec_t ROUT = 33'd1 << 9, RIN = 33'd1 << 10, GRC = 33'd1 << 11, GRB = 33'd1 << 12;
    localparam vec_t GRA = 33'd1 << 13, CONIN = 33'd1 << 14, OUTPORTIN = 33'd1 << 15, LOIN = 33'd1 << 16;
    localparam vec_t HIIN = 33'd1 << 17, INCPC = 33'd1 << 18, PCIN = 33'd1 << 19, ZIN = 33'd1 << 20;
    localparam vec_t YIN = 33'd1 << 21, IRIN = 33'd1 << 22, MDRIN = 33'd1 << 23, MARIN = 33'd1 << 24;
    localparam vec_t COUT = 33'd1 << 25, INPORTOUT = 33'd1 << 26, LOOUT = 33'd1 << 27, HIOUT = 33'd1 << 28;
    localparam vec_t MDROUT = 33'd1 << 29, ZLOWOUT = 33'd1 << 30, ZHIGHOUT = 33'd1 << 31, PCOUT = 33'd1 << 32;
    localparam logic [31:0] JUNK = 32'hD000_0000;
    logic Clock, clear, CON_FF, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
    logic MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, HIin, LOin, OutPortin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, Run;
    logic [4:0] op;
    vec_t dut_vec;
    vec_t seq[$];
    vec_t exp_q[$];
    int total = 0, bad = 0;
    logic watch_write = 0, write_seen = 0;

    control_unit dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .PCin(PCin),
        .IncPC(IncPC), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .op(op), .Run(Run)
    );

    assign dut_vec = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
                      MARin, MDRin, IRin, Yin, Zin, PCin, IncPC, HIin, LOin, OutPortin, CONin,
                      Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, op, Run};

    initial Clock = 0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            total++;
            if (dut_vec !== e) begin
                bad++;
                $display("FAIL cycle t=%0t IR=%h: outputs got %h want %h", $time, IR, dut_vec, e);
            end
        end
    end

    always @(posedge Write) if (watch_write) write_seen = 1;

    function automatic vec_t opf(input logic [4:0] x);
        return {27'b0, x, 1'b0};
    endfunction

    function automatic void add(input vec_t v);
        seq.push_back(v | RUN);
    endfunction

    // Expected output vector for every cycle of one instruction, T0 onward
    function automatic void build(input logic [31:0] ir, input logic con);
        logic [4:0] o;
        o = ir[31:27];
        seq.delete();
        add(PCOUT | MARIN | INCPC | ZIN);
        add(ZLOWOUT | PCIN | READ | MDRIN);
        add(MDROUT | IRIN);
        if (o <= 5'd2) begin
            add(GRB | BAOUT | YIN);
            add(COUT | ZIN | opf(5'd3));
            if (o == 5'd1) add(ZLOWOUT | GRA | RIN);
            else add(ZLOWOUT | MARIN);
            if (o == 5'd0) begin add(READ | MDRIN); add(MDROUT | GRA | RIN); end
            if (o == 5'd2) begin add(GRA | ROUT | MDRIN); add(WRITE); end
        end else if (o <= 5'd11) begin
            add(GRB | ROUT | YIN); add(GRC | ROUT | ZIN | opf(o)); add(ZLOWOUT | GRA | RIN);
        end else if (o <= 5'd14) begin
            add(GRB | ROUT | YIN);
            add(COUT | ZIN | opf(o == 5'd12 ? 5'd3 : o == 5'd13 ? 5'd5 : 5'd6));
            add(ZLOWOUT | GRA | RIN);
        end else if (o <= 5'd16) begin
            add(GRA | ROUT | YIN); add(GRB | ROUT | ZIN | opf(o));
            add(ZLOWOUT | LOIN); add(ZHIGHOUT | HIIN);
        end else if (o == 5'd18) begin
            add(GRA | ROUT | CONIN); add(PCOUT | YIN); add(COUT | ZIN | opf(5'd3));
            add(con ? ZLOWOUT | PCIN : '0);
        end else if (o == 5'd19) add(GRA | ROUT | PCIN);
        else if (o == 5'd20) begin add(PCOUT | RIN); add(GRA | ROUT | PCIN); end
        else if (o == 5'd21) add(INPORTOUT | GRA | RIN);
        else if (o == 5'd22) add(GRA | ROUT | OUTPORTIN);
        else if (o == 5'd23) add(HIOUT | GRA | RIN);
        else if (o == 5'd24) add(LOOUT | GRA | RIN);
        else add('0);
    endfunction

    task automatic pin(input string name, input vec_t got, input vec_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('0);
            @(posedge Clock); #1;
        end
    endtask

    task automatic restart();
        Stop = 0;
        clear = 0;
        idle(2);
        clear = 1;
        idle(1);
    endtask

    // Entered with the DUT just in T0; leaves it in the following state
    task automatic run(input logic [31:0] ir, input logic con, input int stop_step, input int clr_step);
        build(ir, con);
        CON_FF = con;
        for (int i = 0; i < seq.size(); i++) begin
            IR = (i < 2) ? JUNK : ir;
            if (i == clr_step) begin
                exp_q.push_back('0);
                #1 clear = 0;
                @(posedge Clock); #1;
                return;
            end
            exp_q.push_back(seq[i]);
            if (i == stop_step) Stop = 1;
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        clear = 0; Stop = 0; CON_FF = 0; IR = '0;
        @(posedge Clock); #1;
        idle(2);
        build(32'h1800_0000, 1'b0);
        pin("add_len", vec_t'(seq.size()), 33'd6);
        pin("add_T0", seq[0], 33'h1_0114_0001);
        pin("add_T4", seq[4], 33'h0_0010_0A07);
        build(32'h0080_0005, 1'b0);
        pin("ld_len", vec_t'(seq.size()), 33'd8);
        pin("ld_T6", seq[6], 33'h0_0080_0081);
        build(32'h9000_0000, 1'b0);
        pin("br0_T6", seq[6], 33'h1);
        build(32'h7000_0000, 1'b0);
        pin("ori_T4", seq[4], 33'h0_0210_000D);
        build(32'hD000_0000, 1'b0);
        pin("halt_len", vec_t'(seq.size()), 33'd4);
        clear = 1;
        idle(1);
        run(32'h1800_0000, 0, -1, -1);
        run(32'h0080_0005, 0, -1, -1);
        run(32'h0800_0003, 0, -1, -1);
        run(32'h1000_0007, 0, -1, -1);
        run(32'h4800_0000, 0, -1, -1);
        run(32'h6000_0000, 0, -1, -1);
        run(32'h6800_0000, 0, -1, -1);
        run(32'h7000_0000, 0, -1, -1);
        run(32'h7800_0000, 0, -1, -1);
        run(32'h8000_0000, 0, -1, -1);
        run(32'h9000_0000, 0, -1, -1);
        run(32'h9000_0000, 1, -1, -1);
        run(32'h9800_0000, 0, -1, -1);
        run(32'hA000_0000, 0, -1, -1);
        run(32'hA800_0000, 0, -1, -1);
        run(32'hB000_0000, 0, -1, -1);
        run(32'hB800_0000, 0, -1, -1);
        run(32'hC000_0000, 0, -1, -1);
        run(32'hC800_0000, 0, -1, -1);
        run(32'h8800_0000, 0, -1, -1);
        run(32'hF800_0000, 0, -1, -1);
        watch_write = 1;
        run(32'h1000_0007, 0, -1, 6);
        idle(2);
        clear = 1;
        idle(1);
        run(32'h1800_0000, 0, -1, -1);
        watch_write = 0;
        pin("no_write_after_clear", vec_t'(write_seen), 33'd0);
        run(32'h1800_0000, 0, 4, -1);
        idle(3);
        Stop = 0;
        idle(2);
        restart();
        run(32'h0800_0001, 0, -1, -1);
        run(32'hD000_0000, 0, -1, -1);
        idle(10);
        restart();
        run(32'hC800_0000, 0, -1, -1);
        @(negedge Clock); #1;
        pin("queue_drained", vec_t'(exp_q.size()), 33'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
